// File: rtl/mem_access_ctrl.sv
// Sequences one LC-3 memory transaction through MAR/MDR with a bounded ready wait.
// Memory-mapped I/O addresses complete in a single ACCESS cycle.
module mem_access_ctrl #(
  parameter logic [15:0] IO_BASE = 16'hFE00,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned WAIT_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        wr,
  input  logic [15:0] mar_addr,
  input  logic        mem_ready,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        mem_en,
  output logic        mem_ce,
  output logic        io_ce,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDMAR,
    S_LDMDR,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              isIo, effRdy;
  logic              ldMar_q, ldMdrW_q, memEn_q, access_q, busy_q, done_q, err_q;

  always_comb begin
    isIo    = (mar_addr >= IO_BASE);
    effRdy  = isIo | mem_ready;
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LDMAR;
          wr_d    = wr;
        end
      end
      S_LDMAR:  state_d = wr_q ? S_LDMDR : S_ACCESS;
      S_LDMDR:  state_d = S_ACCESS;
      S_ACCESS: begin
        // Ready on the limit cycle takes priority over the timeout abort.
        if (effRdy) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (TO_EN && (cnt_q == LIMIT)) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      ldMar_q  <= 1'b0;
      ldMdrW_q <= 1'b0;
      memEn_q  <= 1'b0;
      access_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      ldMar_q  <= (state_d == S_LDMAR);
      ldMdrW_q <= (state_d == S_LDMDR);
      memEn_q  <= (state_d == S_ACCESS) && !wr_d;
      access_q <= (state_d == S_ACCESS);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
    end
  end

  // Chip selects follow the live MAR value, which only settles once ACCESS begins.
  assign ld_mar = ldMar_q;
  assign ld_mdr = ldMdrW_q | (access_q & ~wr_q & effRdy);
  assign mem_en = memEn_q;
  assign mem_ce = access_q & ~isIo;
  assign io_ce  = access_q & isIo;
  assign mem_we = access_q & wr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a cycle-age transaction model,
// plus directed latency pins for read, write, I/O, timeout and mid-access reset.
module tb_mem_access_ctrl;

  localparam int          TOUT = 16;
  localparam logic [15:0] IOB  = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst_n, start, wr, mem_ready;
  logic [15:0] mar_addr;
  logic        ld_mar, ld_mdr, mem_en, mem_ce, io_ce, mem_we, busy, done, err;

  int checks = 0;
  int failures = 0;

  // Transaction model: age counts cycles since acceptance, finAge is when done/err shows.
  bit mBusy = 1'b0;
  bit mWr;
  int mAge, mWaits, mFinAge, mFinKind;
  int cyc = 0;
  int acceptCyc, doneCyc, errCyc;

  mem_access_ctrl #(.IO_BASE(16'hFE00), .TIMEOUT(16), .WAIT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .mar_addr(mar_addr),
    .mem_ready(mem_ready), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mem_en(mem_en),
    .mem_ce(mem_ce), .io_ce(io_ce), .mem_we(mem_we), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] dutOut();
    return {ld_mar, ld_mdr, mem_en, mem_ce, io_ce, mem_we, busy, done, err};
  endfunction

  function automatic logic [8:0] expOut(input bit r, input logic [15:0] a);
    logic [8:0] e;
    bit io;
    e  = '0;
    io = (a >= IOB);
    if (mBusy) begin
      e[2] = 1'b1;
      if (mFinAge != 0 && mAge == mFinAge) begin
        e[1] = (mFinKind == 1);
        e[0] = (mFinKind == 2);
      end else if (mAge == 1) begin
        e[8] = 1'b1;
      end else if (mWr && mAge == 2) begin
        e[7] = 1'b1;
      end else begin
        e[5] = !io;
        e[4] = io;
        e[3] = mWr;
        e[6] = !mWr;
        e[7] = !mWr && (io || r);
      end
    end
    return e;
  endfunction

  task automatic modelAdvance(input bit s, input bit w, input logic [15:0] a, input bit r);
    if (!mBusy) begin
      if (s) begin
        mBusy = 1'b1; mAge = 1; mWr = w; mWaits = 0; mFinAge = 0; mFinKind = 0;
      end
    end else if (mFinAge != 0 && mAge == mFinAge) begin
      mBusy = 1'b0;
    end else begin
      if (mAge >= (mWr ? 3 : 2)) begin
        if (a >= IOB || r) begin
          mFinAge = mAge + 1; mFinKind = 1;
        end else begin
          mWaits++;
          if (mWaits == TOUT) begin
            mFinAge = mAge + 1; mFinKind = 2;
          end
        end
      end
      mAge++;
    end
  endtask

  task automatic applyStimulus(input bit s, input bit w, input logic [15:0] a, input bit r);
    @(negedge clk);
    start = s; wr = w; mar_addr = a; mem_ready = r;
    #1;
    check("outputs", 32'(dutOut()), 32'(expOut(r, a)));
    if (done) doneCyc = cyc;
    if (err) errCyc = cyc;
    if (!mBusy && s) acceptCyc = cyc;
    modelAdvance(s, w, a, r);
    cyc++;
  endtask

  // waits = number of not-ready ACCESS cycles before ready (large = stuck low).
  task automatic runTxn(input bit w, input logic [15:0] a, input int waits, input bit noise,
                        output int lat);
    int k;
    int accFirst;
    bit r;
    accFirst = w ? 3 : 2;
    doneCyc = -1;
    errCyc = -1;
    applyStimulus(1'b1, w, a, 1'($urandom_range(0, 1)));
    k = 1;
    while (mBusy && k < 60) begin
      if (k >= accFirst) r = (k - accFirst >= waits);
      else r = 1'($urandom_range(0, 1));
      applyStimulus(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), a, r);
      k++;
    end
    check("txn_ends", 32'(mBusy), 32'd0);
    if (doneCyc >= 0) lat = doneCyc - acceptCyc;
    else if (errCyc >= 0) lat = errCyc - acceptCyc;
    else lat = -1;
  endtask

  initial begin
    int lat;
    int expLat;
    bit w;
    logic [15:0] a;
    int waits;

    rst_n = 1'b0; start = 1'b0; wr = 1'b0; mar_addr = 16'h0000; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(dutOut()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runTxn(1'b0, 16'h3000, 0, 1'b0, lat);
    check("t1_read_latency", lat, 3);
    runTxn(1'b0, 16'h3000, 3, 1'b0, lat);
    check("t2_read_wait3_latency", lat, 6);
    check("t2_no_err", errCyc, -1);
    runTxn(1'b1, 16'h3000, 0, 1'b0, lat);
    check("t3_write_latency", lat, 4);
    runTxn(1'b0, 16'hFE02, 999, 1'b0, lat);
    check("t4_io_read_latency", lat, 3);
    runTxn(1'b0, 16'hFDFF, 0, 1'b0, lat);
    check("t4_mem_boundary_latency", lat, 3);
    runTxn(1'b1, 16'hFFFF, 999, 1'b0, lat);
    check("t4_io_write_latency", lat, 4);
    runTxn(1'b0, 16'h3000, 999, 1'b0, lat);
    check("t5_timeout_err_cycle", lat, 18);
    check("t5_no_done", doneCyc, -1);
    runTxn(1'b0, 16'h3000, 15, 1'b0, lat);
    check("t5_ready_on_limit", lat, 18);
    check("t5_limit_no_err", errCyc, -1);
    runTxn(1'b1, 16'h1234, 999, 1'b0, lat);
    check("t5_write_timeout", lat, 19);
    runTxn(1'b0, 16'h3000, 2, 1'b1, lat);
    check("t6_start_noise_latency", lat, 5);

    applyStimulus(1'b1, 1'b0, 16'h3000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h3000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h3000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'(dutOut()), 32'd0);
    mBusy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    runTxn(1'b0, 16'h3000, 0, 1'b0, lat);
    check("t6_after_reset_latency", lat, 3);

    repeat (150) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = IOB + 16'($urandom_range(0, 511));
      else a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) waits = $urandom_range(14, 20);
      else waits = $urandom_range(0, 4);
      runTxn(w, a, waits, 1'($urandom_range(0, 1)), lat);
      if (a >= IOB) expLat = (w ? 3 : 2) + 1;
      else if (waits >= TOUT) expLat = (w ? 3 : 2) + TOUT;
      else expLat = (w ? 3 : 2) + waits + 1;
      check("rand_latency", lat, expLat);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, a, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
